// File: rtl/keypad_scan_entry.sv
// Keypad scanner with debounce and four-digit entry buffer.
//
// Drives one keypad row low at a time and senses the active-low columns. A key
// is accepted after DB_TICKS consecutive matching scan ticks. It is released
// after DB_TICKS consecutive all-high ticks. Each accepted key is shifted into
// a four-digit display buffer.
//
// Ports:
//   clk_i        system clock, all state on rising edge
//   rst_ni       asynchronous active-low reset
//   clr_i        synchronous clear of the digit buffer (all digits blank)
//   col_i[3:0]   keypad column sense, active-low, asynchronous
//   row_o[3:0]   keypad row drive, active-low, exactly one bit low
//   key_valid_o  one-cycle pulse per debounced key press
//   key_code_o   code of last accepted key (4*row + col)
//   digits_o     {d3,d2,d1,d0}, 5 bits each; bit 4 set = blank, bits 3:0 = hex
module keypad_scan_entry #(
  parameter int unsigned SCWIDTH  = 15,
  parameter int unsigned DB_TICKS = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic [3:0]  col_i,
  output logic [3:0]  row_o,
  output logic        key_valid_o,
  output logic [3:0]  key_code_o,
  output logic [19:0] digits_o
);

  localparam int unsigned PreW = SCWIDTH + 1;
  localparam int unsigned CntW = $clog2(DB_TICKS + 1);
  localparam logic [CntW-1:0] DbMax = CntW'(DB_TICKS);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

  state_e            state_q, state_d;
  logic [3:0]        col_m_q, col_s_q;
  logic [PreW-1:0]   pre_q;
  logic              tick;
  logic [3:0]        row_q, row_d, row_rot;
  logic [3:0]        pat_q, pat_d;
  logic [1:0]        key_r_q, key_r_d, key_c_q, key_c_d;
  logic [CntW-1:0]   db_cnt_q, db_cnt_d, db_cnt_inc;
  logic [CntW-1:0]   rel_cnt_q, rel_cnt_d, rel_cnt_inc;
  logic              accept;
  logic              col_one_low;
  logic [3:0]        key_code;
  logic              key_valid_q;
  logic [3:0]        key_code_q;
  logic [19:0]       digits_q;

  // Index of the (single) low bit in an active-low one-hot vector.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  assign tick        = &pre_q;
  assign row_rot     = {row_q[2:0], row_q[3]};
  // Zero or several low columns (multi-key) are treated as no key.
  assign col_one_low = ($countones(~col_s_q) == 1);
  assign db_cnt_inc  = db_cnt_q + CntW'(1);
  assign rel_cnt_inc = rel_cnt_q + CntW'(1);
  assign key_code    = {key_r_q, key_c_q};

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StScan;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; every transition is gated by the scan tick.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        StScan: begin
          if (col_one_low) state_d = StDebounce;
        end
        StDebounce: begin
          if (col_s_q != pat_q)       state_d = StScan;
          else if (db_cnt_inc == DbMax) state_d = StHeld;
        end
        StHeld: begin
          if (col_s_q == 4'b1111 && rel_cnt_inc == DbMax) state_d = StScan;
        end
        default: state_d = StScan;
      endcase
    end
  end

  // Datapath / output next-state logic.
  always_comb begin
    row_d     = row_q;
    pat_d     = pat_q;
    key_r_d   = key_r_q;
    key_c_d   = key_c_q;
    db_cnt_d  = db_cnt_q;
    rel_cnt_d = rel_cnt_q;
    accept    = 1'b0;
    if (tick) begin
      case (state_q)
        StScan: begin
          if (col_one_low) begin
            // Row stays put so the same key keeps being sensed.
            pat_d    = col_s_q;
            key_r_d  = low_idx(row_q);
            key_c_d  = low_idx(col_s_q);
            db_cnt_d = '0;
          end else begin
            row_d = row_rot;
          end
        end
        StDebounce: begin
          if (col_s_q != pat_q) begin
            row_d = row_rot;
          end else begin
            db_cnt_d = db_cnt_inc;
            if (db_cnt_inc == DbMax) begin
              accept    = 1'b1;
              rel_cnt_d = '0;
            end
          end
        end
        StHeld: begin
          if (col_s_q == 4'b1111) begin
            rel_cnt_d = rel_cnt_inc;
            if (rel_cnt_inc == DbMax) row_d = row_rot;
          end else begin
            rel_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_m_q     <= 4'b1111;
      col_s_q     <= 4'b1111;
      pre_q       <= '0;
      row_q       <= 4'b1110;
      pat_q       <= 4'b1111;
      key_r_q     <= '0;
      key_c_q     <= '0;
      db_cnt_q    <= '0;
      rel_cnt_q   <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      digits_q    <= 20'hFFFFF;
    end else begin
      col_m_q     <= col_i;
      col_s_q     <= col_m_q;
      pre_q       <= pre_q + PreW'(1);
      row_q       <= row_d;
      pat_q       <= pat_d;
      key_r_q     <= key_r_d;
      key_c_q     <= key_c_d;
      db_cnt_q    <= db_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      key_valid_q <= accept;
      if (accept) key_code_q <= key_code;
      // Clear wins over a simultaneous accept.
      if (clr_i) begin
        digits_q <= 20'hFFFFF;
      end else if (accept) begin
        digits_q <= {digits_q[14:0], 1'b0, key_code};
      end
    end
  end

  assign row_o       = row_q;
  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;
  assign digits_o    = digits_q;

endmodule
